// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider, raster counters and registered sync/blank strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN; without it frame_cnt
// is tied to zero and no counter is built.
// pix_en is the run-gated decode of the registered divider phase, so a run=0 clock never
// carries a pixel strobe and a resume continues from the held divider phase.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        pix_en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div;
  logic [10:0]      r_hcount;
  logic [10:0]      r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_frame_wrap;
  logic [10:0]      w_hcount_nxt;
  logic [10:0]      w_vcount_nxt;

  assign w_tick       = run & (r_div == DIV_LAST);
  assign w_h_wrap     = (r_hcount == H_LAST);
  assign w_v_wrap     = (r_vcount == V_LAST);
  assign w_frame_wrap = w_tick & w_h_wrap & w_v_wrap;

  assign pix_en      = rst_n & w_tick;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;

  // Divider phase: free-runs 0..CLK_DIV-1 while run is high, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (run) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

  // Next raster position: advance one pixel per tick, wrapping line then frame.
  always_comb begin
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_tick) begin
      w_hcount_nxt = w_h_wrap ? '0 : r_hcount + 11'd1;
      if (w_h_wrap) begin
        w_vcount_nxt = w_v_wrap ? '0 : r_vcount + 11'd1;
      end
    end
  end

  // Counters and strobes share one register stage; strobes decode the next position so
  // they stay aligned with hcount/vcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= ~((w_hcount_nxt >= HS_FIRST) && (w_hcount_nxt <= HS_LAST));
      r_vsync       <= ~((w_vcount_nxt >= VS_FIRST) && (w_vcount_nxt <= VS_LAST));
      r_blank       <= (w_hcount_nxt >= H_VIS) || (w_vcount_nxt >= V_VIS);
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Completed-frame count, bumped on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-timing instance for line/pause/reset checks and a
// small-timing instance (CLK_DIV=1) for frame wrap, randomized run and frame counting.
module tb_vga_timing_gen;

  localparam int S_DIV = 1;
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FCNT_EN = 1'b1;
`else
  localparam bit FCNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, run0, rst1_n, run1;
  logic pix_en0, hsync0, vsync0, blank0, fs0;
  logic pix_en1, hsync1, vsync1, blank1, fs1;
  logic [10:0] hcount0, vcount0, hcount1, vcount1;
  logic [7:0] fcnt0, fcnt1;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst_n(rst0_n), .run(run0), .pix_en(pix_en0),
    .hcount(hcount0), .vcount(vcount0), .hsync(hsync0), .vsync(vsync0),
    .blank(blank0), .frame_start(fs0), .frame_cnt(fcnt0)
  );

  vga_timing_gen #(
    .CLK_DIV(S_DIV),
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .run(run1), .pix_en(pix_en1),
    .hcount(hcount1), .vcount(vcount1), .hsync(hsync1), .vsync(vsync1),
    .blank(blank1), .frame_start(fs1), .frame_cnt(fcnt1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference for the small instance: n1 = clock edges seen with run=1 since reset.
  int n1;
  bit fs1_exp;

  task automatic clk1();
    @(posedge clk);
    if (run1) begin
      n1++;
      fs1_exp = ((n1 % S_DIV) == 0) && (((n1 / S_DIV) % S_FRAME) == 0);
    end else begin
      fs1_exp = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_small(input string tag);
    int pix, h, v, fr;
    pix = n1 / S_DIV;
    h   = pix % S_HT;
    v   = (pix / S_HT) % S_VT;
    fr  = pix / S_FRAME;
    chk({tag, ".hcount"}, 32'(hcount1), h);
    chk({tag, ".vcount"}, 32'(vcount1), v);
    chk({tag, ".hsync"}, 32'(hsync1), (h >= S_HA + S_HF && h < S_HA + S_HF + S_HS) ? 0 : 1);
    chk({tag, ".vsync"}, 32'(vsync1), (v >= S_VA + S_VF && v < S_VA + S_VF + S_VS) ? 0 : 1);
    chk({tag, ".blank"}, 32'(blank1), (h >= S_HA || v >= S_VA) ? 1 : 0);
    chk({tag, ".pix_en"}, 32'(pix_en1),
        (rst1_n && run1 && ((n1 % S_DIV) == S_DIV - 1)) ? 1 : 0);
    chk({tag, ".frame_start"}, 32'(fs1), 32'(fs1_exp));
    chk({tag, ".frame_cnt"}, 32'(fcnt1), FCNT_EN ? (fr % 256) : 0);
  endtask

  typedef struct {
    int   steps;
    logic run;
    int   hc;
    int   vc;
    logic hs;
    logic bl;
    logic pe;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cnt, first, second, npulse;

    // Default-timing vectors; steps are clocks applied before the comparison.
    tbl[0]  = '{0,    1'b1, 0,   0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2,    1'b1, 0,   0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1,    1'b1, 0,   0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1,    1'b1, 1,   0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{2555, 1'b1, 639, 0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1,    1'b1, 640, 0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{63,   1'b1, 655, 0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1,    1'b1, 656, 0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{383,  1'b1, 751, 0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1,    1'b1, 752, 0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{191,  1'b1, 799, 0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1,    1'b1, 0,   1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1201, 1'b1, 300, 1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{50,   1'b0, 300, 1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{2,    1'b1, 300, 1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1,    1'b1, 301, 1, 1'b1, 1'b0, 1'b0};

    rst0_n = 1'b0; run0 = 1'b1;
    rst1_n = 1'b0; run1 = 1'b1;
    n1 = 0; fs1_exp = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state while held, then release with run=1.
    chk("rst.hcount", 32'(hcount0), 0);
    chk("rst.vcount", 32'(vcount0), 0);
    chk("rst.vsync", 32'(vsync0), 1);
    chk("rst.frame_start", 32'(fs0), 0);
    chk("rst.frame_cnt", 32'(fcnt0), 0);
    rst0_n = 1'b1;
    #1;

    for (int i = 0; i < 16; i++) begin
      run0 = tbl[i].run;
      repeat (tbl[i].steps) @(negedge clk);
      chk($sformatf("vec%0d.hcount", i), 32'(hcount0), tbl[i].hc);
      chk($sformatf("vec%0d.vcount", i), 32'(vcount0), tbl[i].vc);
      chk($sformatf("vec%0d.hsync", i), 32'(hsync0), 32'(tbl[i].hs));
      chk($sformatf("vec%0d.vsync", i), 32'(vsync0), 1);
      chk($sformatf("vec%0d.blank", i), 32'(blank0), 32'(tbl[i].bl));
      chk($sformatf("vec%0d.pix_en", i), 32'(pix_en0), 32'(tbl[i].pe));
    end

    // One full line: hsync low for exactly 96 pixel strobes, 800 strobes per line.
    run0 = 1'b1;
    cnt = 0; npulse = 0;
    repeat (3200) begin
      @(negedge clk);
      if (pix_en0 && !hsync0) cnt++;
      if (pix_en0) npulse++;
    end
    chk("line.hsync_pixels", 32'(cnt), 96);
    chk("line.pixels", 32'(npulse), 800);
    chk("line.hcount", 32'(hcount0), 301);
    chk("line.vcount", 32'(vcount0), 2);

    // Asynchronous mid-frame reset, checked before any clock edge arrives.
    #1 rst0_n = 1'b0;
    #1;
    chk("arst0.hcount", 32'(hcount0), 0);
    chk("arst0.vcount", 32'(vcount0), 0);
    chk("arst0.hsync", 32'(hsync0), 1);
    chk("arst0.vsync", 32'(vsync0), 1);
    chk("arst0.blank", 32'(blank0), 0);
    chk("arst0.pix_en", 32'(pix_en0), 0);
    chk("arst0.frame_start", 32'(fs0), 0);
    chk("arst0.frame_cnt", 32'(fcnt0), 0);

    // Small instance: release, then two full frames with run held high.
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    check_small("s_rst");
    first = -1; second = -1; npulse = 0;
    for (int c = 1; c <= 2 * S_FRAME; c++) begin
      run1 = 1'b1;
      clk1();
      check_small("s_frame");
      if (fs1 === 1'b1) begin
        npulse++;
        if (first < 0) first = c;
        else second = c;
      end
    end
    chk("frame.first_pulse", 32'(first), S_FRAME);
    chk("frame.period", 32'(second - first), S_FRAME);
    chk("frame.pulse_count", 32'(npulse), 2);

    // Randomized run toggling against the arithmetic model.
    for (int c = 0; c < 3000; c++) begin
      run1 = ($urandom_range(0, 3) != 0);
      clk1();
      check_small("s_rand");
    end

    // Asynchronous reset of the small instance mid-frame.
    #1 rst1_n = 1'b0;
    #1;
    n1 = 0; fs1_exp = 1'b0;
    check_small("s_arst");
    @(posedge clk);
    @(negedge clk);
    check_small("s_arst_hold");
    rst1_n = 1'b1;
    run1 = 1'b1;
    #1;

    // 257 frames from reset: frame_cnt wraps to 1 when enabled, else stays 0.
    for (int c = 0; c < 257 * S_FRAME; c++) begin
      clk1();
      if ((c % 97) == 0 || c >= 257 * S_FRAME - 3) check_small("s_long");
    end
    chk("fcnt.final", 32'(fcnt1), FCNT_EN ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
